serial_read_buffer: RTL and testbench
=====================================

Name: serial_read_buffer

Overview:
- Receive-side counterpart of SerialWriteBuffer: deserializes up to BUF_SIZE bits from a single serial line into a parallel word.
- Samples in_line once per single-cycle read_sig strobe (generated externally by EdgeDetector on the data clock's capture edge).
- Raises done_sig when the requested number of bits has been collected.
- Used by the MITM bridges to capture bus traffic before forwarding or modification.

Parameters:
BUF_SIZE, 8, maximum bits per transfer and width of data_out
LSB_FIRST, 0, 1: first received bit is stored at bit 0; 0: first received bit is stored at bit BUF_SIZE-1
ACTIVE_LOW, 0, 1: sampled line value is inverted before storage

Ports:
sys_clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
start  input  1  single-cycle pulse; arms a new transfer
read_sig  input  1  single-cycle strobe; sample in_line this cycle
read_count  input  $clog2(BUF_SIZE+1)  number of bits to receive; captured on start
in_line  input  1  serial data, already synchronized to sys_clk by the caller
data_out  output  BUF_SIZE  received word, unused bits zero
bits_read  output  $clog2(BUF_SIZE+1)  bits captured so far in the current transfer
done_sig  output  1  high when idle or finished; low while a transfer is in progress

Behaviour:
- Reset values (rst sampled high at an edge): data_out=0, bits_read=0, done_sig=1, state=IDLE. rst has priority over every other input.
- States:
  - IDLE: done_sig=1.
  - READING: done_sig=0.
  - Reset enters IDLE; transfer completion returns to IDLE.
- IDLE + start:
  - Latch target = min(read_count, BUF_SIZE); values above BUF_SIZE are clamped.
  - Clear data_out and bits_read.
  - If target=0: stay IDLE, done_sig stays 1, data_out=0.
  - Otherwise: enter READING; done_sig=0 from the next edge.
- read_sig in the same cycle as an accepted start is ignored and that bit is not captured.
- READING + read_sig:
  - bit = in_line XOR ACTIVE_LOW.
  - MSB-first (LSB_FIRST=0): store bit at index BUF_SIZE-1-bits_read, so the result is left-justified.
  - LSB-first (LSB_FIRST=1): store bit at index bits_read, so the result is right-justified.
  - bits_read increments.
- Completion:
  - On the edge where bits_read reaches target, the final bit, data_out and done_sig=1 all update together, and the state returns to IDLE.
  - Latency from the last strobe to done_sig is 1 cycle.
- Ignored inputs:
  - start while READING: no restart, no state change.
  - read_sig in IDLE: no effect; data_out holds its last value.
- data_out:
  - Holds its value until the next accepted start or rst.
  - Partial contents are visible during READING, and the stored bits never move.
- bits_read saturates at target and never wraps.
- Reset mid-transfer: aborts immediately; all outputs return to reset values, so a waiter on done_sig is released.
- Width rules:
  - Counter width $clog2(BUF_SIZE+1).
  - Bit-index arithmetic is unsigned.
  - No out-of-range index is generated for any clamped target.

Decomposition:
- Shared package: state encoding (IDLE, READING) and a count-width constant function ($clog2(BUF_SIZE+1)), shared with SerialWriteBuffer.
- No sub-module: the logic is a single FSM plus shift/index register.
- Strobe generation stays in the existing EdgeDetector, instantiated by the caller.

Test Plan:
- BUF_SIZE=8, MSB-first:
  - start, read_count=8, line bits 1,0,0,1,1,1,0,0 on 8 strobes -> data_out=0x9C, done_sig rises 1 cycle after the 8th strobe, bits_read=8.
  - start, read_count=6, bits 1,1,1,1,0,0 -> data_out=0xF0 (6'o74<<2).
  - start, read_count=4, bits 0,1,0,1 -> data_out=0x50.
- Mid-transfer reset: read_count=6, 3 strobes then rst pulse -> data_out=0x00, bits_read=0, done_sig=1 the cycle after rst; following 4-bit transfer 0,1,0,1 -> 0x50.
- LSB_FIRST=1, ACTIVE_LOW=1: read_count=8, line levels 1,1,0,0,0,1,1,0 (logical 0,0,1,1,1,0,0,1) -> data_out=0x9C.
- Edge cases:
  - read_count=0 -> done_sig never drops, data_out=0x00.
  - read_count=12 -> clamped; completes after 8 strobes.
  - start and read_sig in the same cycle -> that bit is not captured.
  - start pulsed while READING -> ignored; transfer result unchanged.

Source files
------------

// File: rtl/serial_read_buffer_pkg.sv
// Shared definitions for the serial read/write buffers.
// State encoding and counter-width helper.
package serial_read_buffer_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    READING = 1'b1
  } srb_state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_read_buffer.sv
// Serial-to-parallel receive buffer.
// Samples in_line on each read_sig strobe until the target count is reached.
module serial_read_buffer
  import serial_read_buffer_pkg::*;
#(
  parameter int BUF_SIZE   = 8,
  parameter int LSB_FIRST  = 0,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          read_sig,
  input  logic [cnt_width(BUF_SIZE)-1:0] read_count,
  input  logic                          in_line,
  output logic [BUF_SIZE-1:0]           data_out,
  output logic [cnt_width(BUF_SIZE)-1:0] bits_read,
  output logic                          done_sig
);

  localparam int CW = cnt_width(BUF_SIZE);
  localparam int IW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] MAXC = CW'(BUF_SIZE);

  srb_state_e          state_q;
  logic [BUF_SIZE-1:0] data_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       tgt_q;
  logic                done_q;

  logic [CW-1:0] tgt_d;
  logic [CW-1:0] cnt_d;
  logic [IW-1:0] pos_d;
  logic [IW-1:0] idx_d;
  logic          bit_d;

  assign tgt_d = (read_count > MAXC) ? MAXC : read_count;
  assign cnt_d = cnt_q + CW'(1);
  assign bit_d = in_line ^ INV;
  assign pos_d = cnt_q[IW-1:0];

  // cnt_q < tgt_q <= BUF_SIZE while reading, so the index stays in range
  assign idx_d = (LSB_FIRST != 0) ? pos_d
               : IW'(BUF_SIZE - 1) - pos_d;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            data_q <= '0;
            cnt_q  <= '0;
            tgt_q  <= tgt_d;
            if (tgt_d != '0) begin
              state_q <= READING;
              done_q  <= 1'b0;
            end
          end
        end
        READING: begin
          if (read_sig) begin
            data_q[idx_d] <= bit_d;
            cnt_q         <= cnt_d;
            if (cnt_d == tgt_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign bits_read = cnt_q;
  assign done_sig  = done_q;

endmodule

// File: tb/tb_serial_read_buffer.sv
// Scoreboard bench for serial_read_buffer.
// Two instances: MSB-first/active-high and LSB-first/active-low.
module tb_serial_read_buffer;

  localparam int BS = 8;
  localparam int CW = $clog2(BS + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          read_sig = 1'b0;
  logic          in_line = 1'b0;
  logic [CW-1:0] read_count = '0;

  logic [BS-1:0] d0, d1;
  logic [CW-1:0] br0, br1;
  logic          dn0, dn1;

  always #5 clk = ~clk;

  serial_read_buffer #(
    .BUF_SIZE(BS), .LSB_FIRST(0), .ACTIVE_LOW(0)
  ) u0 (
    .sys_clk(clk), .rst(rst), .start(start),
    .read_sig(read_sig), .read_count(read_count),
    .in_line(in_line), .data_out(d0),
    .bits_read(br0), .done_sig(dn0)
  );

  serial_read_buffer #(
    .BUF_SIZE(BS), .LSB_FIRST(1), .ACTIVE_LOW(1)
  ) u1 (
    .sys_clk(clk), .rst(rst), .start(start),
    .read_sig(read_sig), .read_count(read_count),
    .in_line(in_line), .data_out(d1),
    .bits_read(br1), .done_sig(dn1)
  );

  int vec = 0;
  int mis = 0;

  typedef struct {
    logic [7:0] e0;
    logic [7:0] e1;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  bit m_bits[$];
  int m_tgt = 0;
  bit m_act = 1'b0;
  int edge_n = 0;
  bit mon_en = 1'b0;

  function automatic logic [7:0] mdata(bit lsb, bit inv);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < m_bits.size(); i++) begin
      if (m_bits[i] ^ inv) begin
        if (lsb) r = r | (8'd1 << i);
        else     r = r | (8'd1 << (7 - i));
      end
    end
    return r;
  endfunction

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %0h want %0h @edge %0d",
               nm, act, exp, edge_n);
    end
  endtask

  task automatic cyc(bit rv, bit st, bit [CW-1:0] rc,
                     bit rs, bit ln);
    rst = rv;
    start = st;
    read_count = rc;
    read_sig = rs;
    in_line = ln;
    @(posedge clk);
    edge_n++;
    if (rv) begin
      if (m_act) sbq.push_back('{8'h00, 8'h00, edge_n});
      m_act = 1'b0;
      m_bits.delete();
      m_tgt = 0;
    end else if (!m_act) begin
      if (st) begin
        m_bits.delete();
        m_tgt = (int'(rc) > BS) ? BS : int'(rc);
        m_act = (m_tgt > 0);
      end
    end else if (rs) begin
      m_bits.push_back(ln);
      if (m_bits.size() == m_tgt) begin
        m_act = 1'b0;
        sbq.push_back('{mdata(0, 0), mdata(1, 1), edge_n});
      end
    end
    #1;
    rst = 1'b0;
    start = 1'b0;
    read_sig = 1'b0;
  endtask

  task automatic xfer(int rc, logic [11:0] pat, int n,
                      bit sw);
    cyc(0, 1, CW'(rc), sw, 1'b1);
    for (int i = 0; i < n; i++) begin
      cyc(0, 0, '0, 1, pat[n-1-i]);
      cyc(0, 0, '0, 0, 1'b0);
    end
  endtask

  // Per-cycle model comparison plus completion scoreboard
  bit prev_dn = 1'b1;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("bits_read0", 32'(br0), 32'(m_bits.size()));
        check("bits_read1", 32'(br1), 32'(m_bits.size()));
        check("done0", 32'(dn0), 32'(!m_act));
        check("done1", 32'(dn1), 32'(!m_act));
        check("data0", 32'(d0), 32'(mdata(0, 0)));
        check("data1", 32'(d1), 32'(mdata(1, 1)));
        if (dn0 && !prev_dn) begin
          if (sbq.size() == 0) begin
            check("sb_unexpected_done", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            check("sb_data0", 32'(d0), 32'(e.e0));
            check("sb_data1", 32'(d1), 32'(e.e1));
            check("sb_latency", 32'(edge_n), 32'(e.cyc));
          end
        end
        prev_dn = dn0;
      end
    end
  end

  initial begin
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 1, 1);
    check("rst_data", 32'(d0), 32'h0);
    check("rst_bits", 32'(br0), 32'h0);
    check("rst_done", 32'(dn0), 32'h1);
    mon_en = 1'b1;

    xfer(8, 12'b1001_1100, 8, 0);
    check("tp_9c", 32'(d0), 32'h9C);
    check("tp_9c_cnt", 32'(br0), 32'd8);
    xfer(6, 12'b11_1100, 6, 0);
    check("tp_f0", 32'(d0), 32'hF0);
    xfer(4, 12'b0101, 4, 0);
    check("tp_50", 32'(d0), 32'h50);

    cyc(0, 1, CW'(6), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1, 1);
    cyc(1, 0, '0, 0, 0);
    check("mid_rst_data", 32'(d0), 32'h0);
    check("mid_rst_bits", 32'(br0), 32'h0);
    check("mid_rst_done", 32'(dn0), 32'h1);
    xfer(4, 12'b0101, 4, 0);
    check("after_rst_50", 32'(d0), 32'h50);

    xfer(8, 12'b1100_0110, 8, 0);
    check("lsb_al_9c", 32'(d1), 32'h9C);
    check("msb_c6", 32'(d0), 32'hC6);

    cyc(0, 1, '0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 1, 1);
    check("rc0_done", 32'(dn0), 32'h1);
    check("rc0_data", 32'(d0), 32'h0);

    xfer(12, 12'b1010_1010, 8, 0);
    check("clamp_done", 32'(dn0), 32'h1);
    check("clamp_cnt", 32'(br0), 32'd8);
    check("clamp_aa", 32'(d0), 32'hAA);
    cyc(0, 0, '0, 1, 1);
    check("idle_strobe", 32'(d0), 32'hAA);

    xfer(4, 12'b0101, 4, 1);
    check("st_rs_same", 32'(d0), 32'h50);

    cyc(0, 1, CW'(4), 0, 0);
    cyc(0, 0, '0, 1, 1);
    cyc(0, 0, '0, 1, 0);
    cyc(0, 1, CW'(8), 0, 0);
    cyc(0, 0, '0, 1, 1);
    cyc(0, 0, '0, 1, 1);
    check("restart_ign", 32'(d0), 32'hB0);
    check("restart_cnt", 32'(br0), 32'd4);

    for (int t = 0; t < 300; t++) begin
      int n;
      cyc(0, 1, CW'($urandom_range(0, 15)),
          1'($urandom), 1'($urandom));
      n = 0;
      while (m_act && n < 200) begin
        cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) == 0),
            CW'($urandom_range(0, 15)),
            1'($urandom), 1'($urandom));
        n++;
      end
      if ($urandom_range(0, 3) == 0) cyc(0, 0, '0, 1, 1'($urandom));
    end

    cyc(0, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 0);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, mis);
    $finish;
  end

endmodule
